// File: rtl/eq4_sweep_driver.sv
// Purpose : operand sweeper for the 4-bit equality comparator. Drives every
//           (a,b) pair onto the slider bus with load strobes, samples res2 and
//           keeps match/error counts plus a sticky pass flag.
// Latency : 3+SETTLE cycles per pair; 2^(2*WIDTH)*(3+SETTLE)+1 cycles from
//           the start edge to the done pulse (1281 with the defaults).
// Backpressure: none; the comparator is assumed to settle within SETTLE cycles.
//
// Ports:
//   clock, reset_n      rising-edge clock, async active-low reset
//   start               level, only looked at while idle
//   res2                comparator equality result
//   n0, p1, p2          operand bus and n1/n2 load strobes (registered)
//   busy, done, pass    sweep status; done is a one-cycle pulse
//   eq_count            pairs sampled with res2=1
//   err_count           pairs where res2 disagreed with a==b
//   fail_pair           {a,b} of the first failing pair
//
// Build option: define EQ4_SWEEP_STOP_ON_ERR_EN to end the sweep at the
// first mismatching pair instead of running all pairs.

module eq4_sweep_driver #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               res2,
  output logic [WIDTH-1:0]   n0,
  output logic               p1,
  output logic               p2,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   eq_count,
  output logic [2*WIDTH:0]   err_count,
  output logic [2*WIDTH-1:0] fail_pair
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = PW + 1;
  // WAIT counts down from SETTLE-1 to 0, giving exactly SETTLE cycles.
  localparam logic [3:0] WAIT_INIT = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     pair_q, pair_d;
  logic [3:0]        wait_q, wait_d;
  logic [WIDTH-1:0]  n0_q, n0_d;
  logic              p1_q, p1_d;
  logic              p2_q, p2_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CW-1:0]     eq_q, eq_d;
  logic [CW-1:0]     err_q, err_d;
  logic [PW-1:0]     fail_q, fail_d;

  logic [WIDTH-1:0]  a_w, b_w, a_next_w;
  logic [PW-1:0]     pair_inc_w;
  logic              mism_w;
  logic              stop_w;

  assign a_w        = pair_q[PW-1:WIDTH];
  assign b_w        = pair_q[WIDTH-1:0];
  assign pair_inc_w = pair_q + PW'(1);
  assign a_next_w   = pair_inc_w[PW-1:WIDTH];
  assign mism_w     = res2 != (a_w == b_w);

`ifdef EQ4_SWEEP_STOP_ON_ERR_EN
  assign stop_w = (&pair_q) | mism_w;
`else
  assign stop_w = &pair_q;
`endif

  // Outputs are computed for the state being entered, so every output is a
  // flop and n0 is already stable for the whole cycle its strobe is high.
  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    wait_d  = wait_q;
    n0_d    = n0_q;
    p1_d    = 1'b0;
    p2_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    eq_d    = eq_q;
    err_d   = err_q;
    fail_d  = fail_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          eq_d    = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          fail_d  = '0;
          busy_d  = 1'b1;
          n0_d    = a_w;
          p1_d    = 1'b1;
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        n0_d    = b_w;
        p2_d    = 1'b1;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        wait_d  = WAIT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == 4'd0) begin
          state_d = S_SAMPLE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        eq_d = eq_q + CW'(res2);
        if (mism_w) begin
          err_d = err_q + CW'(1);
          // Only the first failure of a sweep is recorded.
          if (err_q == '0) begin
            fail_d = pair_q;
          end
        end
        if (stop_w) begin
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = S_DONE;
        end else begin
          pair_d  = pair_inc_w;
          n0_d    = a_next_w;
          p1_d    = 1'b1;
          state_d = S_LOAD_A;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        pair_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pair_q  <= '0;
      wait_q  <= '0;
      n0_q    <= '0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      eq_q    <= '0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      wait_q  <= wait_d;
      n0_q    <= n0_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      eq_q    <= eq_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign n0        = n0_q;
  assign p1        = p1_q;
  assign p2        = p2_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign eq_count  = eq_q;
  assign err_count = err_q;
  assign fail_pair = fail_q;

endmodule

// File: tb/tb_eq4_sweep_driver.sv
// Bench for eq4_sweep_driver: a comparator model answers the strobes, and
// every sweep cycle is checked against the expected schedule and running
// counts derived from pair arithmetic.

module tb_eq4_sweep_driver;

  localparam int WIDTH  = 4;
  localparam int SETTLE = 2;
  localparam int PER    = 3 + SETTLE;
  localparam int NP     = 1 << (2 * WIDTH);

`ifdef EQ4_SWEEP_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 start = 1'b0;
  logic                 res2;
  logic [WIDTH-1:0]     n0;
  logic                 p1, p2, busy, done, pass;
  logic [2*WIDTH:0]     eq_count, err_count;
  logic [2*WIDTH-1:0]   fail_pair;

  eq4_sweep_driver #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .res2      (res2),
    .n0        (n0),
    .p1        (p1),
    .p2        (p2),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .eq_count  (eq_count),
    .err_count (err_count),
    .fail_pair (fail_pair)
  );

  always #5 clock = ~clock;

  // Comparator model: 0 = ideal (latches n0 on the strobes), 1 = stuck 0,
  // 2 = stuck 1.
  int               mode = 0;
  logic [WIDTH-1:0] n1_m = '0;
  logic [WIDTH-1:0] n2_m = '0;
  always @(posedge clock) begin
    if (p1) n1_m <= n0;
    if (p2) n2_m <= n0;
  end
  assign res2 = (mode == 0) ? (n1_m == n2_m) : (mode == 2);

  int tests = 0;
  int fails = 0;

  // Running results after the first c pairs have been sampled.
  int eq_pref   [0:NP];
  int err_pref  [0:NP];
  int fail_pref [0:NP];
  int m_npairs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, 64'({n0, p1, p2, busy, done, pass, eq_count, err_count, fail_pair}), 64'd0);
  endtask

  task automatic build_model(input int md);
    eq_pref[0]   = 0;
    err_pref[0]  = 0;
    fail_pref[0] = 0;
    m_npairs     = NP;
    for (int p = 0; p < NP; p++) begin
      int a, b;
      bit want, got;
      a    = p >> WIDTH;
      b    = p % (1 << WIDTH);
      want = (a == b);
      got  = (md == 0) ? want : (md == 2);
      eq_pref[p+1]   = eq_pref[p] + int'(got);
      err_pref[p+1]  = err_pref[p] + int'(got != want);
      fail_pref[p+1] = (err_pref[p] == 0 && got != want) ? p : fail_pref[p];
      if (STOP && got != want) begin
        m_npairs = p + 1;
        break;
      end
    end
  endtask

  // Cycle n counts from 1 = first cycle after the start edge; cycle len is
  // the done cycle.
  task automatic check_cycle(input int n, input int len);
    int c, pr, ph;
    logic             e_p1, e_p2, e_done, e_pass;
    logic [WIDTH-1:0] e_n0;
    logic [63:0]      exp_v, act_v;
    if (n < len) begin
      c      = (n - 1) / PER;
      pr     = c;
      ph     = (n - 1) % PER;
      e_p1   = (ph == 0);
      e_p2   = (ph == 1);
      e_n0   = (ph == 0) ? WIDTH'(pr >> WIDTH) : WIDTH'(pr);
      e_done = 1'b0;
      e_pass = 1'b0;
    end else begin
      c      = m_npairs;
      pr     = m_npairs - 1;
      e_p1   = 1'b0;
      e_p2   = 1'b0;
      e_n0   = WIDTH'(pr);
      e_done = 1'b1;
      e_pass = (err_pref[c] == 0);
    end
    exp_v = 64'({e_n0, e_p1, e_p2, 1'b1, e_done, e_pass,
                 9'(eq_pref[c]), 9'(err_pref[c]), 8'(fail_pref[c])});
    act_v = 64'({n0, p1, p2, busy, done, pass, eq_count, err_count, fail_pair});
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL cycle %0d: got n0=%h p1=%b p2=%b busy=%b done=%b pass=%b eq=%0d err=%0d fp=%h, expected n0=%h p1=%b p2=%b busy=1 done=%b pass=%b eq=%0d err=%0d fp=%h",
               n, n0, p1, p2, busy, done, pass, eq_count, err_count, fail_pair,
               e_n0, e_p1, e_p2, e_done, e_pass, eq_pref[c], err_pref[c], fail_pref[c]);
    end
  endtask

  task automatic run_sweep(input int md, input bit repulse, input int abort_at,
                           input int lit_len, input int lit_eq, input int lit_err,
                           input int lit_fail, input bit lit_pass);
    int len, last, p1n, p2n, ovl, done_at;
    p1n = 0; p2n = 0; ovl = 0; done_at = 0;
    mode = md;
    build_model(md);
    len  = m_npairs * PER + 1;
    last = (abort_at != 0) ? abort_at : len;
    @(negedge clock);
    start = 1'b1;
    for (int n = 1; n <= last; n++) begin
      @(negedge clock);
      start = repulse && (n == 100 || n == 700);
      check_cycle(n, len);
      if (p1) p1n++;
      if (p2) p2n++;
      if (p1 && p2) ovl++;
      if (done && done_at == 0) done_at = n;
    end
    if (abort_at != 0) begin
      #2 reset_n = 1'b0;
      #1 chk_zero("reset_mid_sweep");
      @(negedge clock);
      chk_zero("reset_held");
      reset_n = 1'b1;
    end else begin
      @(negedge clock);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_strobes", 64'({p1, p2}), 64'd0);
      chk("done_cycle", 64'(done_at), 64'(lit_len));
      chk("eq_count", 64'(eq_count), 64'(lit_eq));
      chk("err_count", 64'(err_count), 64'(lit_err));
      chk("fail_pair", 64'(fail_pair), 64'(lit_fail));
      chk("pass", 64'(pass), 64'(lit_pass));
      chk("p1_pulses", 64'(p1n), 64'((lit_len - 1) / PER));
      chk("p2_pulses", 64'(p2n), 64'((lit_len - 1) / PER));
      chk("strobe_overlap", 64'(ovl), 64'd0);
    end
  endtask

  initial begin
    #12 chk_zero("reset_hold");
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk_zero("reset_idle");
    end

    run_sweep(0, 1'b0, 0, 1281, 16, 0, 8'h00, 1'b1);
`ifdef EQ4_SWEEP_STOP_ON_ERR_EN
    run_sweep(1, 1'b0, 0, 6, 0, 1, 8'h00, 1'b0);
    run_sweep(2, 1'b0, 0, 11, 2, 1, 8'h01, 1'b0);
`else
    run_sweep(1, 1'b0, 0, 1281, 0, 16, 8'h00, 1'b0);
    run_sweep(2, 1'b0, 0, 1281, 256, 240, 8'h01, 1'b0);
`endif
    run_sweep(0, 1'b1, 0, 1281, 16, 0, 8'h00, 1'b1);
    run_sweep(0, 1'b0, 500, 0, 0, 0, 0, 1'b0);
    run_sweep(0, 1'b0, 0, 1281, 16, 0, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
